// File: rtl/l1d_wt_cache.sv
// l1d_wt_cache: write-through, no-write-allocate L1 data cache between the
// core load/store port and the MAU. Tag/valid/data held in flop arrays,
// per-set round-robin replacement with invalid-way preference.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   core_req_* (val/addr/cop/wdata/size) in, core_req_ack/core_ack_data out
//   mau_req_* (val/nc/we/addr/wdata/be) out, mau_req_ack/mau_ack_nc/mau_ack_data in
module l1d_wt_cache #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned WAY_NUM = 4,
   parameter int unsigned SET_NUM = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req_val,
   input  logic [ADDR_W-1:0] core_req_addr,
   input  logic [2:0]        core_req_cop,
   input  logic [31:0]       core_req_wdata,
   input  logic [1:0]        core_req_size,
   output logic              core_req_ack,
   output logic [31:0]       core_ack_data,
   output logic              mau_req_val,
   output logic              mau_req_nc,
   output logic              mau_req_we,
   output logic [ADDR_W-1:0] mau_req_addr,
   output logic [31:0]       mau_req_wdata,
   output logic [3:0]        mau_req_be,
   input  logic              mau_req_ack,
   input  logic              mau_ack_nc,
   input  logic [LINE_W-1:0] mau_ack_data
);

   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned IDX_W  = $clog2(SET_NUM);
   localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned WSEL_W = OFF_W - 2;
   localparam int unsigned WAY_W  = $clog2(WAY_NUM);

   localparam logic [2:0] COP_RD   = 3'd0;
   localparam logic [2:0] COP_WR   = 3'd1;
   localparam logic [2:0] COP_RDNC = 3'd2;
   localparam logic [2:0] COP_WRNC = 3'd3;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MAU_RD, S_MAU_WR, S_MAU_NC} state_e;

   state_e state_q, state_d;

   logic [TAG_W-1:0]   tag_arr  [SET_NUM][WAY_NUM];
   logic [LINE_W-1:0]  data_arr [SET_NUM][WAY_NUM];
   logic [WAY_NUM-1:0] valid_q  [SET_NUM];
   logic [WAY_W-1:0]   rr_q     [SET_NUM];

   // Captured request (word address only; byte lanes kept pre-shifted)
   logic [ADDR_W-3:0] req_waddr_q;
   logic [2:0]        req_cop_q;
   logic [3:0]        req_be_q;
   logic [31:0]       req_wlanes_q;
   logic              hit_q;
   logic [WAY_W-1:0]  hit_way_q;
   logic [31:0]       hit_word_q;
   logic              flush_ack_q;

   logic [TAG_W-1:0]  req_tag, tag_c;
   logic [IDX_W-1:0]  req_idx, idx_c;
   logic [WSEL_W-1:0] req_wsel, wsel_c;

   assign req_tag  = req_waddr_q[ADDR_W-3 -: TAG_W];
   assign req_idx  = req_waddr_q[WSEL_W +: IDX_W];
   assign req_wsel = req_waddr_q[WSEL_W-1:0];
   assign tag_c    = core_req_addr[ADDR_W-1 -: TAG_W];
   assign idx_c    = core_req_addr[OFF_W +: IDX_W];
   assign wsel_c   = core_req_addr[2 +: WSEL_W];

   // Byte-lane alignment of the incoming request
   logic [3:0]  be_base_c, be_c;
   logic [31:0] wlanes_c;
   always_comb begin
      case (core_req_size)
         2'd1:    be_base_c = 4'b0001;
         2'd2:    be_base_c = 4'b0011;
         default: be_base_c = 4'b1111;
      endcase
      be_c     = be_base_c << core_req_addr[1:0];
      wlanes_c = core_req_wdata << {core_req_addr[1:0], 3'b000};
   end

   // Tag lookup against the set addressed by the incoming request
   logic             hit_c;
   logic [WAY_W-1:0] hit_way_c;
   logic [31:0]      hit_word_c;
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      for (int unsigned w = 0; w < WAY_NUM; w++) begin
         if (!hit_c && valid_q[idx_c][w] && tag_arr[idx_c][w] == tag_c) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
      end
      hit_word_c = data_arr[idx_c][hit_way_c][{wsel_c, 5'b00000} +: 32];
   end

   // Victim: lowest invalid way, else the set's round-robin pointer
   logic             vic_found_c;
   logic [WAY_W-1:0] vic_way_c;
   always_comb begin
      vic_found_c = 1'b0;
      vic_way_c   = rr_q[req_idx];
      for (int unsigned w = 0; w < WAY_NUM; w++) begin
         if (!vic_found_c && !valid_q[req_idx][w]) begin
            vic_found_c = 1'b1;
            vic_way_c   = WAY_W'(w);
         end
      end
   end

   logic        accept_c, flush_c, refill_c, wr_hit_c;
   logic [31:0] merged_c, refill_word_c;
   assign accept_c      = (state_q == S_IDLE) && core_req_val && !flush_ack_q;
   assign flush_c       = accept_c && (core_req_cop == 3'd4);
   assign refill_c      = (state_q == S_MAU_RD) && mau_req_ack && !mau_ack_nc;
   assign wr_hit_c      = (state_q == S_LOOKUP) && (req_cop_q == COP_WR) && hit_q;
   assign refill_word_c = mau_ack_data[{req_wsel, 5'b00000} +: 32];

   always_comb begin
      for (int unsigned b = 0; b < 4; b++)
         merged_c[8*b +: 8] = req_be_q[b] ? req_wlanes_q[8*b +: 8] : hit_word_q[8*b +: 8];
   end

   // Next-state and next MAU request
   logic              mval_d, mnc_d, mwe_d, flush_ack_d;
   logic [ADDR_W-1:0] maddr_d;
   logic [31:0]       mwdata_d;
   logic [3:0]        mbe_d;
   always_comb begin
      state_d     = state_q;
      mval_d      = mau_req_val;
      mnc_d       = mau_req_nc;
      mwe_d       = mau_req_we;
      maddr_d     = mau_req_addr;
      mwdata_d    = mau_req_wdata;
      mbe_d       = mau_req_be;
      flush_ack_d = accept_c && (core_req_cop > COP_WRNC);
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               case (core_req_cop)
                  COP_RD, COP_WR: state_d = S_LOOKUP;
                  COP_RDNC, COP_WRNC: begin
                     state_d  = S_MAU_NC;
                     mval_d   = 1'b1;
                     mnc_d    = 1'b1;
                     mwe_d    = (core_req_cop == COP_WRNC);
                     maddr_d  = {core_req_addr[ADDR_W-1:2], 2'b00};
                     mwdata_d = wlanes_c;
                     mbe_d    = be_c;
                  end
                  default: ;
               endcase
            end
         end
         S_LOOKUP: begin
            if (req_cop_q == COP_RD) begin
               if (hit_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d  = S_MAU_RD;
                  mval_d   = 1'b1;
                  mnc_d    = 1'b0;
                  mwe_d    = 1'b0;
                  maddr_d  = {req_tag, req_idx, OFF_W'(0)};
                  mwdata_d = '0;
                  mbe_d    = 4'b1111;
               end
            end else begin
               state_d  = S_MAU_WR;
               mval_d   = 1'b1;
               mnc_d    = 1'b0;
               mwe_d    = 1'b1;
               maddr_d  = {req_waddr_q, 2'b00};
               mwdata_d = req_wlanes_q;
               mbe_d    = req_be_q;
            end
         end
         S_MAU_RD, S_MAU_WR, S_MAU_NC: begin
            if (mau_req_ack) begin
               state_d = S_IDLE;
               mval_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Core completion is same-cycle with the MAU response, so it is decoded here
   always_comb begin
      core_req_ack  = flush_ack_q;
      core_ack_data = '0;
      case (state_q)
         S_LOOKUP: begin
            if (req_cop_q == COP_RD && hit_q) begin
               core_req_ack  = 1'b1;
               core_ack_data = hit_word_q;
            end
         end
         S_MAU_RD: begin
            if (mau_req_ack) begin
               core_req_ack  = 1'b1;
               core_ack_data = mau_ack_nc ? mau_ack_data[31:0] : refill_word_c;
            end
         end
         S_MAU_WR: core_req_ack = mau_req_ack;
         S_MAU_NC: begin
            if (mau_req_ack) begin
               core_req_ack = 1'b1;
               if (req_cop_q == COP_RDNC) core_ack_data = mau_ack_data[31:0];
            end
         end
         default: ;
      endcase
   end

   // State, registered MAU outputs, captured request, valid and rr pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         flush_ack_q   <= 1'b0;
         mau_req_val   <= 1'b0;
         mau_req_nc    <= 1'b0;
         mau_req_we    <= 1'b0;
         mau_req_addr  <= '0;
         mau_req_wdata <= '0;
         mau_req_be    <= '0;
         req_waddr_q   <= '0;
         req_cop_q     <= '0;
         req_be_q      <= '0;
         req_wlanes_q  <= '0;
         hit_q         <= 1'b0;
         hit_way_q     <= '0;
         hit_word_q    <= '0;
         for (int unsigned s = 0; s < SET_NUM; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q       <= state_d;
         flush_ack_q   <= flush_ack_d;
         mau_req_val   <= mval_d;
         mau_req_nc    <= mnc_d;
         mau_req_we    <= mwe_d;
         mau_req_addr  <= maddr_d;
         mau_req_wdata <= mwdata_d;
         mau_req_be    <= mbe_d;
         if (accept_c) begin
            req_waddr_q  <= core_req_addr[ADDR_W-1:2];
            req_cop_q    <= core_req_cop;
            req_be_q     <= be_c;
            req_wlanes_q <= wlanes_c;
            hit_q        <= hit_c;
            hit_way_q    <= hit_way_c;
            hit_word_q   <= hit_word_c;
         end
         if (flush_c) begin
            for (int unsigned s = 0; s < SET_NUM; s++) begin
               valid_q[s] <= '0;
               rr_q[s]    <= '0;
            end
         end else if (refill_c) begin
            valid_q[req_idx][vic_way_c] <= 1'b1;
            if (!vic_found_c) rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
         end
      end
   end

   // Tag and data arrays are not reset; valid bits qualify them
   always_ff @(posedge clk) begin
      if (refill_c) begin
         tag_arr[req_idx][vic_way_c]  <= req_tag;
         data_arr[req_idx][vic_way_c] <= mau_ack_data;
      end else if (wr_hit_c) begin
         data_arr[req_idx][hit_way_q][{req_wsel, 5'b00000} +: 32] <= merged_c;
      end
   end

   logic aligned_c;
   assign aligned_c = (core_req_size == 2'd1) ? 1'b1 :
                      (core_req_size == 2'd2) ? !core_req_addr[0] :
                      (core_req_addr[1:0] == 2'b00);

   a_aligned: assert property (@(posedge clk) disable iff (!rst_n)
      (accept_c && core_req_cop != 3'd4) |-> aligned_c);
   a_legal_cop: assert property (@(posedge clk) disable iff (!rst_n)
      accept_c |-> (core_req_cop <= 3'd4));

endmodule

// File: doc/l1d_wt_cache.md
# l1d_wt_cache

Parametrised write-through, no-write-allocate L1 data cache sitting between the core load/store port and the MAU. Generalises the first-generation L1D with configurable address width, line width, associativity and set count, an explicit request FSM, per-set round-robin replacement with invalid-way preference, sub-word byte-lane handling, and a single-cycle flush-invalidate operation. Tag, valid and data arrays are internal flop arrays.

## Interface
- ADDR_W, 32: core address width.
- LINE_W, 256: line width in bits; power of two, ≥64.
- WAY_NUM, 4: associativity; power of two, ≥2.
- SET_NUM, 32: sets; power of two, ≥2.
- Derived: OFF_W=clog2(LINE_W/8), IDX_W=clog2(SET_NUM), TAG_W=ADDR_W-IDX_W-OFF_W. Data path is fixed at 32 bits, byte enables 4 bits.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- core_req_val  in  1  request valid; held with all fields stable until core_req_ack.
- core_req_addr  in  ADDR_W  byte address.
- core_req_cop  in  3  0=RD, 1=WR, 2=RDNC, 3=WRNC, 4=FLUSH; others are illegal.
- core_req_wdata  in  32  store data, LSB-aligned.
- core_req_size  in  2  1=byte, 2=half, other=word.
- core_req_ack  out  1  one-cycle completion pulse.
- core_ack_data  out  32  aligned word containing the addressed bytes; valid with ack for RD/RDNC.
- mau_req_val  out  1  MAU request; held stable until mau_req_ack.
- mau_req_nc  out  1  non-cacheable.
- mau_req_we  out  1  write.
- mau_req_addr  out  ADDR_W  line-aligned for refill, word-aligned otherwise.
- mau_req_wdata  out  32  store data shifted into byte lanes.
- mau_req_be  out  4  byte enables.
- mau_req_ack  in  1  one-cycle response pulse.
- mau_ack_nc  in  1  response is non-cacheable; data in bits [31:0].
- mau_ack_data  in  LINE_W  refill line / NC read word.

## Operation
- Address split {tag, idx, off}. be = (size 1: 4'b0001, 2: 4'b0011, else 4'b1111) << addr[1:0]; wlanes = wdata << 8*addr[1:0]. Misaligned accesses are illegal (assertion).
- FSM states: IDLE, LOOKUP, MAU_RD, MAU_WR, MAU_NC.
- IDLE: on core_req_val, capture request and read tag/valid/data of set idx. RD/WR -> LOOKUP; RDNC/WRNC -> MAU_NC; FLUSH clears all valid bits and round-robin pointers, pulses core_req_ack next cycle, remains IDLE.
- LOOKUP, hit = valid & tag match in exactly one way.
  - RD hit: core_req_ack=1, core_ack_data = hit line word off[OFF_W-1:2] -> IDLE.
  - RD miss: -> MAU_RD (nc=0, we=0, addr {tag,idx,0}).
  - WR: if hit, merge wlanes under be into hit way's word; always -> MAU_WR (nc=0, we=1). Miss leaves arrays untouched.
- MAU_RD: on mau_req_ack write mau_ack_data and tag into victim way, set valid; core_req_ack same cycle, core_ack_data taken from mau_ack_data -> IDLE.
- Victim: lowest-index invalid way; if none, rr_ptr[idx], which then increments mod WAY_NUM.
- MAU_WR/MAU_NC: on mau_req_ack pulse core_req_ack -> IDLE. RDNC returns mau_ack_data[31:0]; cache arrays never accessed for NC.
- mau_ack_nc on an MAU_RD response: treated as NC read, no array write.

## Timing
- Reset values: core_req_ack=0, core_ack_data=0, mau_req_val=0, mau_req_nc=0, mau_req_we=0, mau_req_addr=0, mau_req_wdata=0, mau_req_be=0; FSM=IDLE; all valid=0, rr_ptr=0. Tag/data arrays not reset.
- Read hit: request seen cycle 0, ack cycle 1; next request accepted cycle 2.
- Miss/write/NC: mau_req_val asserted from cycle 2 (NC: cycle 1) until the mau_req_ack cycle; core ack in that same cycle; mau_req_val low the cycle after.
- FLUSH: ack cycle 1; a request in cycle 2 misses.
- One outstanding request at a time; core_req_val while not IDLE is ignored until acknowledged.
- Reset mid-transaction: all outputs return to reset values immediately; in-flight MAU transaction abandoned (MAU shares rst_n).

## Test plan
- RD 0x0000_0040 on cold cache -> MAU refill request addr 0x0000_0040, nc=0; line word1=0xDEADBEEF; read 0x44 -> ack with 0xDEADBEEF, reread hit-acks at cycle 1 with no MAU traffic.
- WR size 1, addr 0x45, wdata 0xAB after refill -> MAU be=4'b0010, wdata 0x0000AB00; reread 0x44 -> 0xDEADABEF.
- WR miss to 0x2000 -> MAU write issued, subsequent RD 0x2000 misses (no-write-allocate).
- Fill WAY_NUM+1 lines of one set -> first 4 fill ways 0..3, fifth evicts way 0, sixth way 1.
- RDNC 0x80 with mau_ack_data[31:0]=0x12345678 -> ack data 0x12345678, later RD 0x80 misses.
- FLUSH after fills -> all prior addresses miss; rst_n low during MAU_RD -> mau_req_val=0 immediately, clean restart.
